// File: rtl/rate_detector_if.sv
// Bundle of the per-channel strobe input and the rate/reset/lock outputs of rate_detector.
// The detector itself connects through the slave modport.
`timescale 1ns/1ps
interface rate_detector_if #(
  parameter int NUM_CH   = 8,
  parameter int NUM_RATE = 5
);
  logic [NUM_CH-1:0]          ack_i;
  logic [NUM_RATE*NUM_CH-1:0] rate_o;
  logic [NUM_CH-1:0]          rst_ch_o;
  logic [NUM_CH-1:0]          lock_o;

  modport master (output ack_i, input rate_o, rst_ch_o, lock_o);
  modport slave  (input ack_i, output rate_o, rst_ch_o, lock_o);
endinterface

// File: rtl/rate_detector.sv
// Per-channel sample-rate classifier: counts strobes over a shared clock window, debounces
// the class over STABLE windows and drives one-hot rate, lock and pipeline reset per channel.
`timescale 1ns/1ps
module rate_detector #(
  parameter int NUM_CH      = 8,
  parameter int NUM_RATE    = 5,
  parameter int WINDOW_LOG2 = 16,
  parameter int CNT_W       = 9,
  parameter int TH_MIN      = 16,
  parameter int TH_32_441   = 50,
  parameter int TH_441_48   = 61,
  parameter int TH_48_96    = 96,
  parameter int TH_96_192   = 192,
  parameter int TH_MAX      = 320,
  parameter int STABLE      = 2
) (
  input logic           clk,
  input logic           rst,
  rate_detector_if.slave bus
);

  localparam int AGR_W = (STABLE < 2) ? 1 : $clog2(STABLE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    CLS_32K  = 3'd0,
    CLS_441K = 3'd1,
    CLS_48K  = 3'd2,
    CLS_96K  = 3'd3,
    CLS_192K = 3'd4,
    CLS_NONE = 3'd5
  } cls_e;

  function automatic cls_e classify(input logic [CNT_W-1:0] c);
    int n;
    n = int'(c);
    if (n < TH_MIN)         return CLS_NONE;
    else if (n < TH_32_441) return CLS_32K;
    else if (n < TH_441_48) return CLS_441K;
    else if (n < TH_48_96)  return CLS_48K;
    else if (n < TH_96_192) return CLS_96K;
    else if (n <= TH_MAX)   return CLS_192K;
    else                    return CLS_NONE;
  endfunction

  logic [WINDOW_LOG2-1:0] win;
  logic                   wend;

  logic [CNT_W-1:0] cnt       [NUM_CH];
  cls_e             committed [NUM_CH];
  cls_e             cand      [NUM_CH];
  logic [AGR_W-1:0] agree     [NUM_CH];

  logic [CNT_W:0]   sum           [NUM_CH];
  logic [CNT_W-1:0] closing       [NUM_CH];
  cls_e             cls           [NUM_CH];
  cls_e             committed_nxt [NUM_CH];
  cls_e             cand_nxt      [NUM_CH];
  logic [AGR_W-1:0] agree_nxt     [NUM_CH];
  logic [NUM_CH-1:0] commit;

  logic [NUM_RATE*NUM_CH-1:0] rate_nxt, rate_q;
  logic [NUM_CH-1:0]          lock_nxt, lock_q;
  logic [NUM_CH-1:0]          rst_ch_nxt, rst_ch_q;

  assign wend = &win;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    rate_nxt   = '0;
    lock_nxt   = '0;
    rst_ch_nxt = '0;
    commit     = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sum[ch]     = {1'b0, cnt[ch]} + {{CNT_W{1'b0}}, bus.ack_i[ch]};
      closing[ch] = sum[ch][CNT_W] ? CNT_MAX : sum[ch][CNT_W-1:0];
      cls[ch]     = classify(closing[ch]);

      committed_nxt[ch] = committed[ch];
      cand_nxt[ch]      = cand[ch];
      agree_nxt[ch]     = agree[ch];

      if (wend) begin
        if (cls[ch] == committed[ch]) begin
          agree_nxt[ch] = '0;
        end else if (cls[ch] == cand[ch] && agree[ch] != '0) begin
          agree_nxt[ch] = agree[ch] + AGR_W'(1);
          if (int'(agree[ch]) + 1 == STABLE) commit[ch] = 1'b1;
        end else begin
          cand_nxt[ch]  = cls[ch];
          agree_nxt[ch] = AGR_W'(1);
          if (STABLE == 1) commit[ch] = 1'b1;
        end
      end

      if (commit[ch]) begin
        committed_nxt[ch] = cls[ch];
        agree_nxt[ch]     = '0;
      end

      // The commit pulse rides on rst_ch for exactly the cycle after the window end.
      if (committed_nxt[ch] != CLS_NONE)
        rate_nxt[NUM_RATE*ch +: NUM_RATE] = NUM_RATE'(1) << committed_nxt[ch];
      lock_nxt[ch]   = (committed_nxt[ch] != CLS_NONE);
      rst_ch_nxt[ch] = (committed_nxt[ch] == CLS_NONE) | commit[ch];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win      <= '0;
      rate_q   <= '0;
      lock_q   <= '0;
      rst_ch_q <= '1;
      // NOTE: per-channel state lives in flops, not a RAM, so every entry is reset explicitly.
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt[ch]       <= '0;
        committed[ch] <= CLS_NONE;
        cand[ch]      <= CLS_NONE;
        agree[ch]     <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values.
      win      <= win + WINDOW_LOG2'(1);
      rate_q   <= rate_nxt;
      lock_q   <= lock_nxt;
      rst_ch_q <= rst_ch_nxt;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt[ch]       <= wend ? '0 : closing[ch];
        committed[ch] <= committed_nxt[ch];
        cand[ch]      <= cand_nxt[ch];
        agree[ch]     <= agree_nxt[ch];
      end
    end
  end

  assign bus.rate_o   = rate_q;
  assign bus.lock_o   = lock_q;
  assign bus.rst_ch_o = rst_ch_q;

endmodule
